// File: rtl/replica_pkg.sv
// Shared types and sizes for the replica ring and its ordering drain.
package replica_pkg;

  localparam int unsigned city_num     = 16;
  localparam int unsigned city_num_log = $clog2(city_num);

  typedef logic [7:0][7:0] replica_data_t;
  typedef logic [3:0][7:0] drain_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: distributed RAM plus a head register that always holds the oldest entry.
module sync_fifo #(
  parameter int unsigned width = 64,
  parameter int unsigned depth = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [width-1:0]         wdata,
  input  logic                     pop,
  output logic [width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int unsigned aw = $clog2(depth);
  localparam int unsigned cw = aw + 1;

  logic [width-1:0] mem_q [depth];
  logic [aw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [aw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [aw-1:0]    rd_next;
  logic [cw-1:0]    count_q, count_d;
  logic [width-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == cw'(depth));
  assign empty = (count_q == '0);
  assign rdata = head_q;
  assign count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    rd_next  = rd_ptr_q + aw'(1);

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + aw'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_next;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + cw'(1);
      2'b01:   count_d = count_q - cw'(1);
      default: count_d = count_q;
    endcase

    // Head refills from the incoming word when it is the only candidate, else from RAM.
    if (empty && push_ok) begin
      head_d = wdata;
    end else if (pop_ok) begin
      if (count_q == cw'(1)) begin
        head_d = wdata;
      end else begin
        head_d = mem_q[rd_next];
      end
    end

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear && !reset) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/ordering_drain.sv
// Buffers 64-bit ordering beats and re-emits them as tagged 32-bit words toward the host DMA.
module ordering_drain
  import replica_pkg::replica_data_t;
  import replica_pkg::drain_word_t;
#(
  parameter int unsigned city_num    = replica_pkg::city_num,
  parameter int unsigned replica_num = 32,
  parameter int unsigned fifo_depth  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           ord_valid,
  input  replica_data_t                  ord_data,
  input  logic                           out_ready,
  output logic                           out_valid,
  output drain_word_t                    out_data,
  output logic                           out_last,
  output logic [$clog2(replica_num)-1:0] out_replica,
  output logic                           out_done,
  output logic                           overflow,
  output logic [$clog2(fifo_depth):0]    level
);

  localparam int unsigned words_per_rep = city_num / 4;
  localparam int unsigned word_w        = $clog2(words_per_rep);
  localparam int unsigned rep_w         = $clog2(replica_num);

  logic          fifo_full, fifo_empty;
  replica_data_t fifo_head;
  logic          push, pop, xfer, load;

  logic [63:0]       hold_q, hold_d;
  logic              hv_q, hv_d;
  logic              half_q, half_d;
  logic [word_w-1:0] word_q, word_d;
  logic [rep_w-1:0]  rep_q, rep_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  sync_fifo #(
    .width (64),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .wdata (ord_data),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (level)
  );

  assign out_valid   = hv_q;
  assign out_data    = half_q ? hold_q[63:32] : hold_q[31:0];
  assign out_last    = hv_q && (word_q == word_w'(words_per_rep - 1));
  assign out_replica = rep_q;
  assign out_done    = done_q;
  assign overflow    = ovf_q;

  always_comb begin
    hold_d = hold_q;
    hv_d   = hv_q;
    half_d = half_q;
    word_d = word_q;
    rep_d  = rep_q;
    done_d = 1'b0;
    ovf_d  = ovf_q;

    xfer = hv_q && out_ready;
    load = !fifo_empty && (!hv_q || (half_q && xfer));
    push = ord_valid && !fifo_full;
    pop  = load;

    if (load) begin
      hold_d = fifo_head;
      hv_d   = 1'b1;
      half_d = 1'b0;
    end else if (xfer) begin
      if (!half_q) begin
        half_d = 1'b1;
      end else begin
        hv_d   = 1'b0;
        half_d = 1'b0;
      end
    end

    // Word/replica tagging advances on every accepted word.
    if (xfer) begin
      if (word_q == word_w'(words_per_rep - 1)) begin
        word_d = '0;
        if (rep_q == rep_w'(replica_num - 1)) begin
          rep_d  = '0;
          done_d = 1'b1;
        end else begin
          rep_d = rep_q + rep_w'(1);
        end
      end else begin
        word_d = word_q + word_w'(1);
      end
    end

    // A full FIFO drops the beat even if a pop frees a slot this cycle.
    if (ord_valid && fifo_full) begin
      ovf_d = 1'b1;
    end

    if (clear) begin
      hold_d = '0;
      hv_d   = 1'b0;
      half_d = 1'b0;
      word_d = '0;
      rep_d  = '0;
      done_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      hv_q   <= 1'b0;
      half_q <= 1'b0;
      word_q <= '0;
      rep_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      hv_q   <= hv_d;
      half_q <= half_d;
      word_q <= word_d;
      rep_q  <= rep_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ordering_drain.sv
// Scoreboard bench for ordering_drain: directed scenarios plus randomized traffic.
module tb_ordering_drain;

  localparam int unsigned CN  = 16;
  localparam int unsigned RN  = 4;
  localparam int unsigned FD  = 16;
  localparam int unsigned WPR = CN / 4;

  logic             clk = 1'b0;
  logic             reset, clear, ord_valid, out_ready;
  logic [7:0][7:0]  ord_data;
  logic             out_valid, out_last, out_done, overflow;
  logic [31:0]      out_data;
  logic [1:0]       out_replica;
  logic [4:0]       level;

  ordering_drain #(
    .city_num    (CN),
    .replica_num (RN),
    .fifo_depth  (FD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .ord_valid   (ord_valid),
    .ord_data    (ord_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_replica (out_replica),
    .out_done    (out_done),
    .overflow    (overflow),
    .level       (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  rep;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mq[$];
  int          m_cur = 0;
  int          m_ovf = 0;
  int          k = 0;
  int          gen = 0;
  int          errors = 0;
  int          checks = 0;
  int          peak_lvl = 0;
  int          done_seen = 0;
  int          rmode = 0;
  int          cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats occupy the FIFO queue, then a holding stage that emits 2 words.
  always @(posedge clk) begin
    logic        full, ne, xf, ld;
    logic [63:0] b;
    exp_t        e;
    if (reset || clear) begin
      mq.delete();
      sb.delete();
      m_cur = 0;
      m_ovf = 0;
      k = 0;
      gen++;
    end else begin
      full = (mq.size() == FD);
      ne   = (mq.size() > 0);
      xf   = (m_cur > 0) && out_ready;
      ld   = ne && (m_cur == 0 || (m_cur == 1 && xf));
      if (ld) begin
        void'(mq.pop_front());
        m_cur = 2;
      end else if (xf) begin
        m_cur--;
      end
      if (ord_valid) begin
        if (full) begin
          m_ovf = 1;
        end else begin
          b = ord_data;
          mq.push_back(b);
          for (int w = 0; w < 2; w++) begin
            e.data = (w == 0) ? b[31:0] : b[63:32];
            e.last = ((k % WPR) == WPR - 1);
            e.rep  = 2'((k / WPR) % RN);
            k++;
            sb.push_back(e);
          end
        end
      end
    end
  end

  // Monitor: compares every accepted word and the visible status against the model.
  always @(negedge clk) begin
    int   last_gen;
    logic stall_v, done_exp;
    logic [31:0] st_data;
    logic st_last;
    logic [1:0] st_rep;
    exp_t e;
    if (gen != last_gen) begin
      last_gen = gen;
      stall_v  = 1'b0;
      done_exp = 1'b0;
      check("replica_after_flush", out_replica, 0);
    end
    check("out_valid", out_valid, (m_cur > 0));
    check("level", level, mq.size());
    check("overflow", overflow, m_ovf);
    if (out_done || done_exp) check("out_done", out_done, done_exp);
    if (out_done) done_seen++;
    done_exp = 1'b0;
    if (int'(level) > peak_lvl) peak_lvl = int'(level);
    if (stall_v && out_valid) begin
      check("stall_data", out_data, st_data);
      check("stall_last", out_last, st_last);
      check("stall_rep", out_replica, st_rep);
    end
    stall_v = 1'b0;
    if (out_valid && !out_ready) begin
      stall_v = 1'b1;
      st_data = out_data;
      st_last = out_last;
      st_rep  = out_replica;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", out_data, 64'hdead);
      end else begin
        e = sb.pop_front();
        check("word_data", out_data, e.data);
        check("word_last", out_last, e.last);
        check("word_rep", out_replica, e.rep);
        if (e.last && e.rep == 2'(RN - 1)) done_exp = 1'b1;
      end
    end
  end

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rmode == 1) out_ready = pat[cyc % 4];
    else if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [63:0] b);
    ord_valid = 1'b1;
    ord_data  = b;
    step();
    ord_valid = 1'b0;
  endtask

  function automatic logic [63:0] mk_beat(input int b);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = 8'(b * 8 + i);
    return v;
  endfunction

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (mq.size() == 0 && m_cur == 0 && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("drain_done", ok, 1'b1);
    repeat (3) step();
  endtask

  task automatic full_xfer();
    for (int b = 0; b < 8; b++) begin
      ord_valid = 1'b1;
      ord_data  = mk_beat(b);
      step();
    end
    ord_valid = 1'b0;
    drain();
  endtask

  initial begin
    int d0;
    reset = 1'b1; clear = 1'b0; ord_valid = 1'b0; ord_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_replica", out_replica, 0);
    check("rst_done", out_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_level", level, 0);
    step();

    // Single beat latency and word order
    out_ready = 1'b1;
    send(64'h0706050403020100);
    @(negedge clk);
    check("lat_t1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_t2_valid", out_valid, 1);
    check("lat_t2_data", out_data, 32'h03020100);
    step();
    drain();

    // Full transfer
    pulse_clear();
    d0 = done_seen;
    full_xfer();
    check("full_done_count", done_seen - d0, 1);
    check("full_overflow", overflow, 0);

    // Backpressure 1,0,0,1
    pulse_clear();
    rmode = 1;
    peak_lvl = 0;
    d0 = done_seen;
    full_xfer();
    rmode = 0;
    check("bp_peak_le8", (peak_lvl <= 8), 1);
    check("bp_done_count", done_seen - d0, 1);

    // Overflow: 18 beats into a stalled sink
    pulse_clear();
    out_ready = 1'b0;
    for (int b = 0; b < 18; b++) begin
      ord_valid = 1'b1;
      ord_data  = mk_beat(b);
      step();
    end
    ord_valid = 1'b0;
    @(negedge clk);
    check("ovf_level", level, 16);
    check("ovf_flag", overflow, 1);
    check("ovf_sb_words", sb.size(), 34);
    step();
    out_ready = 1'b1;
    drain();

    // Clear mid-stream with level 5 and the high half presented
    pulse_clear();
    out_ready = 1'b1;
    send(mk_beat(1));
    send(mk_beat(2));
    drain();
    out_ready = 1'b0;
    for (int b = 0; b < 6; b++) send(mk_beat(10 + b));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("pre_clear_level", level, 5);
    check("pre_clear_replica", out_replica, 1);
    check("pre_clear_high", out_data, 32'h57565554);
    step();
    pulse_clear();
    @(negedge clk);
    check("clr_valid", out_valid, 0);
    check("clr_level", level, 0);
    check("clr_overflow", overflow, 0);
    check("clr_replica", out_replica, 0);
    step();
    out_ready = 1'b1;
    send(mk_beat(20));
    drain();

    // Reset mid-burst
    pulse_clear();
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      ord_valid = 1'b1;
      ord_data  = mk_beat(b);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    ord_valid = 1'b0;
    @(negedge clk);
    check("rmid_valid", out_valid, 0);
    check("rmid_data", out_data, 0);
    check("rmid_replica", out_replica, 0);
    check("rmid_level", level, 0);
    check("rmid_overflow", overflow, 0);
    step();
    d0 = done_seen;
    full_xfer();
    check("rmid_done_count", done_seen - d0, 1);

    // Randomized traffic with random backpressure and occasional clears
    pulse_clear();
    rmode = 2;
    for (int i = 0; i < 500; i++) begin
      ord_valid = ($urandom_range(0, 2) != 0);
      ord_data  = {$urandom, $urandom};
      clear     = ($urandom_range(0, 99) == 0);
      step();
    end
    ord_valid = 1'b0;
    clear = 1'b0;
    rmode = 0;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/ordering_drain.md
# ordering_drain

Downstream drain for the replica ring's ordering output stream. It captures the 64-bit `ordering_out_valid`/`ordering_out_data` beats the ring emits at full rate with no backpressure, and buffers them in a FIFO. It re-emits them as a 32-bit valid/ready stream toward the host DMA, tagging each word with its replica index and marking the last word of each replica's tour. Overflow is never silent: a sticky flag records any dropped beat.

## Interface
Parameters:
- `city_num`, default `replica_pkg::city_num`; cities per tour, multiple of 8 and ≥ 8.
- `replica_num`, default 32; replicas per full ordering transfer.
- `fifo_depth`, default 16; beat FIFO depth, power of 2, ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `clear` in 1: one-cycle pulse. Zeroes the counters, empties the FIFO, clears `overflow`.
- `ord_valid` in 1: beat strobe from the ring.
- `ord_data` in [7:0][7:0]: 8 city indices; byte 0 is the earliest city in tour order.
- `out_ready` in 1: sink accepts a word.
- `out_valid` out 1: word available.
- `out_data` out 32: 4 city bytes.
- `out_last` out 1: last word of the current replica.
- `out_replica` out `$clog2(replica_num)`: replica index of the word.
- `out_done` out 1: one-cycle pulse after the last word of replica `replica_num-1` is accepted.
- `overflow` out 1: sticky; a beat was dropped.
- `level` out `$clog2(fifo_depth)+1`: FIFO occupancy.

## Operation
- Reset value of all outputs is 0. After reset the FIFO is empty and all counters are 0.
- **Push:** when `ord_valid` is high and the FIFO is not full at the start of the cycle, the beat is written.
  - If the FIFO is full, the beat is dropped and `overflow` is set. This holds even if a pop happens in the same cycle; there is no bypass.
- **Output register:** a 64-bit holding register, a `hv` (holding valid) bit and a `half` bit.
  - `out_data = half ? hold[63:32] : hold[31:0]`.
  - `hold` bytes 0..3 are ord_data[0..3]; the low half goes out first.
  - `out_valid = hv`.
- **Load:** the head beat is popped into `hold` when the FIFO is non-empty and either
  - `hv` = 0, or
  - the word currently presented has `half` = 1 and `out_ready` = 1.
  - On load, `half` is set to 0.
- **Handshake:** a word transfers when `out_valid && out_ready`.
  - After the low-half word transfers, `half` goes to 1.
  - After the high-half word transfers, the register reloads from the FIFO if it is non-empty; otherwise `hv` goes to 0.
  - While `out_valid` is high and `out_ready` is low, `out_data`, `out_last` and `out_replica` hold stable.
- **Word counter:** counts 0 .. `city_num/4 - 1` per replica.
  - `out_last` = 1 when the counter equals `city_num/4 - 1`.
  - On transfer of the last word, the counter wraps to 0 and `out_replica` increments.
- **Completion:** when replica `replica_num-1` wraps, `out_replica` wraps to 0 and `out_done` pulses in the next cycle.
- **`clear`:** has priority over push, pop and transfer in the same cycle. Its effect matches reset, except that `clear` is a functional input.
- **Reset mid-burst:** all state is discarded, including the in-flight word and the partial replica count. No drain is attempted.

## Timing
- Latency: a beat pushed in cycle t is visible in the FIFO in t+1 and loaded into `hold` at the end of t+1. `out_valid` rises in t+2 with the low half.
- Throughput: one beat per 2 cycles with `out_ready` held high. Therefore a full-rate input burst grows the FIFO by about 1 entry per 2 beats.
- Back-to-back: the high-half transfer and the next low half need no idle cycle between them.
- `level` is registered and reflects the pushes and pops of the previous cycle.
- `overflow` rises in the cycle after the dropped beat.
- `out_done` lasts exactly 1 cycle.

## Structure
- `replica_pkg` holds `city_num`, `city_num_log` and a new `drain_word_t` typedef (logic [3:0][7:0]). `replica_data_t` remains the beat type.
- Sub-module `sync_fifo` #(width, depth): single clock, synchronous reset, with `full`/`empty`/`count` and registered read data. Implement it as distributed RAM with a head register.
- The top-level `ordering_drain` contains the holding register, the half/word/replica counters and the overflow logic.

## Test plan
Default for all scenarios: `city_num=16`, `replica_num=4`, `fifo_depth=16`.
- **Single beat:** one beat with bytes 0x00..0x07 and `out_ready`=1 -> `out_valid` in t+2.
  - Words 0x03020100 then 0x07060504, `out_last`=0, `out_replica`=0.
- **Full transfer:** 8 beats, cities = beat*8+byte, `out_ready`=1 -> 16 words in order.
  - `out_last` on words 3, 7, 11 and 15; `out_replica` steps 0..3.
  - `out_done` pulses once after word 15; `overflow`=0.
- **Backpressure:** same as the full transfer, with `out_ready` toggling 1,0,0,1.
  - Required: data is stable during stalls, no loss, same word order, `level` peaks ≤ 8.
- **Overflow:** `out_ready`=0 with 18 consecutive beats.
  - Required: `level`=16, `overflow`=1; 17 beats retained (16 in the FIFO, 1 in `hold`); beat 18 is dropped.
  - After `out_ready`=1, the first 34 words come out intact.
- **Clear mid-stream:** `clear` pulsed with `level`=5 and `half`=1.
  - Next cycle: `out_valid`=0, `level`=0, `overflow`=0, `out_replica`=0.
  - A new beat then emits from word 0.
- **Reset mid-burst:** reset asserted for 1 cycle during a burst.
  - All outputs are 0 the next cycle. A subsequent transfer matches the full-transfer scenario exactly.
